// File: rtl/c2f_chunk_reader.sv
// Drains full chunks of the C2F ring RAM as a ready/valid 64-bit word stream
// and acknowledges each chunk to the producer once its last word has left.
module c2f_chunk_reader #(
    parameter int IDX_WIDTH = 2,
    parameter int OFF_WIDTH = 7
) (
    input  logic                           pcieClk_in,
    input  logic                           reset_in,
    input  logic [IDX_WIDTH-1:0]           c2fWrPtr_in,
    output logic [IDX_WIDTH-1:0]           c2fRdPtr_out,
    output logic                           c2fDTAck_out,
    output logic [IDX_WIDTH+OFF_WIDTH-1:0] ramAddr_out,
    input  logic [63:0]                    ramData_in,
    output logic [63:0]                    data_out,
    output logic                           valid_out,
    input  logic                           ready_in,
    output logic                           last_out
);

    typedef enum logic {IDLE, FETCH} state_t;

    localparam logic [OFF_WIDTH-1:0] LAST_OFF = '1;

    state_t                r_state;
    logic [IDX_WIDTH-1:0]  r_fetch_chunk;
    logic [OFF_WIDTH-1:0]  r_fetch_off;
    logic                  r_inflight;
    logic                  r_inflight_last;

    // Two-entry output FIFO: entry 0 is the head and drives the stream ports.
    logic                  r_vld0, r_lst0, r_vld1, r_lst1;
    logic [63:0]           r_dat0, r_dat1;
    logic [IDX_WIDTH-1:0]  r_rd_ptr;
    logic                  r_ack;

    logic                  w_pop;
    logic [1:0]            w_occ;
    logic                  w_credit;
    logic                  w_pending;
    logic                  w_issue;
    logic                  w_fetch_last;
    logic                  w_ld0_tail;
    logic                  w_ld0_ram;
    logic                  w_ld1_ram;

    assign w_pop = r_vld0 & ready_in;

    // A word leaving this cycle frees its slot in time for a read issued now,
    // which is what lets the stream sustain one word per cycle.
    assign w_occ    = {1'b0, r_vld0} + {1'b0, r_vld1} + {1'b0, r_inflight};
    assign w_credit = (w_occ - {1'b0, w_pop}) < 2'd2;

    // IDLE issues offset 0 in the same cycle it sees a pending chunk, giving
    // the two-cycle start latency and no bubble between consecutive chunks.
    assign w_pending    = (r_state == FETCH) || (r_fetch_chunk != c2fWrPtr_in);
    assign w_issue      = w_pending & w_credit;
    assign w_fetch_last = (r_fetch_off == LAST_OFF);

    assign ramAddr_out = {r_fetch_chunk, r_fetch_off};

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge pcieClk_in) begin
        if (reset_in) begin
            r_state         <= IDLE;
            r_fetch_chunk   <= '0;
            r_fetch_off     <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
        end else begin
            r_inflight      <= w_issue;
            r_inflight_last <= w_issue & w_fetch_last;
            if (w_issue) begin
                r_fetch_off <= r_fetch_off + OFF_WIDTH'(1);
                if (w_fetch_last) begin
                    r_fetch_chunk <= r_fetch_chunk + IDX_WIDTH'(1);
                    r_state       <= IDLE;
                end else begin
                    r_state <= FETCH;
                end
            end
        end
    end

    assign w_ld0_tail = w_pop & r_vld1;
    assign w_ld0_ram  = r_inflight & ((w_pop & ~r_vld1) | ~r_vld0);
    assign w_ld1_ram  = r_inflight & ((w_pop & r_vld1) | (~w_pop & r_vld0));

    always_ff @(posedge pcieClk_in) begin
        if (reset_in) begin
            r_vld0   <= 1'b0;
            r_lst0   <= 1'b0;
            r_vld1   <= 1'b0;
            r_lst1   <= 1'b0;
            r_ack    <= 1'b0;
            r_rd_ptr <= '0;
        end else begin
            r_vld0 <= w_ld0_tail | w_ld0_ram | (r_vld0 & ~w_pop);
            r_vld1 <= w_ld1_ram | (r_vld1 & ~w_pop);
            if (w_ld0_tail) begin
                r_lst0 <= r_lst1;
            end else if (w_ld0_ram) begin
                r_lst0 <= r_inflight_last;
            end
            if (w_ld1_ram) begin
                r_lst1 <= r_inflight_last;
            end
            r_ack <= w_pop & r_lst0;
            if (w_pop & r_lst0) begin
                r_rd_ptr <= r_rd_ptr + IDX_WIDTH'(1);
            end
        end
    end

    // NOTE: the data registers are not reset; the valid bits qualify them, so
    // clearing 128 bits of payload would buy nothing.
    always_ff @(posedge pcieClk_in) begin
        if (w_ld0_tail) begin
            r_dat0 <= r_dat1;
        end else if (w_ld0_ram) begin
            r_dat0 <= ramData_in;
        end
        if (w_ld1_ram) begin
            r_dat1 <= ramData_in;
        end
    end

    assign data_out     = r_dat0;
    assign valid_out    = r_vld0;
    assign last_out     = r_lst0;
    assign c2fRdPtr_out = r_rd_ptr;
    assign c2fDTAck_out = r_ack;

endmodule

// File: tb/tb_c2f_chunk_reader.sv
// Scoreboard bench for c2f_chunk_reader with 4-word chunks; the RAM returns
// {chunk, offset} replicated, so every word identifies its own address.
module tb_c2f_chunk_reader;

    localparam int IW  = 2;
    localparam int OW  = 2;
    localparam int WPC = 4;

    typedef struct packed {
        logic [63:0] data;
        logic        last;
    } word_t;

    logic              clk = 1'b0;
    logic              reset_in = 1'b1;
    logic              ready_in = 1'b1;
    logic [IW-1:0]     wr_ptr = '0;
    logic [IW-1:0]     rd_ptr;
    logic              dtack;
    logic [IW+OW-1:0]  ram_addr;
    logic [63:0]       ram_data;
    logic [63:0]       data_out;
    logic              valid_out;
    logic              last_out;

    c2f_chunk_reader #(.IDX_WIDTH(IW), .OFF_WIDTH(OW)) dut (
        .pcieClk_in   (clk),
        .reset_in     (reset_in),
        .c2fWrPtr_in  (wr_ptr),
        .c2fRdPtr_out (rd_ptr),
        .c2fDTAck_out (dtack),
        .ramAddr_out  (ram_addr),
        .ramData_in   (ram_data),
        .data_out     (data_out),
        .valid_out    (valid_out),
        .ready_in     (ready_in),
        .last_out     (last_out)
    );

    always #5 clk = ~clk;

    // Synchronous-read RAM: data follows the address by one cycle.
    always @(posedge clk) ram_data <= {16{ram_addr}};

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    word_t         exp_q[$];
    int            xfer_cyc_q[$];
    int            n_checks = 0;
    int            n_fail = 0;
    int            ack_seen = 0;
    logic [IW-1:0] exp_rd = '0;
    logic          pend_ack = 1'b0;
    logic          prev_stall = 1'b0;
    logic [63:0]   prev_data = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    // Monitor: samples on the falling edge, so a valid&ready seen here is the
    // transfer that the next rising edge commits.
    always @(negedge clk) begin
        if (reset_in) begin
            exp_q.delete();
            exp_rd     = '0;
            pend_ack   = 1'b0;
            prev_stall = 1'b0;
        end else begin
            word_t w;
            check("dtack", 64'(dtack), 64'(pend_ack));
            check("rd_ptr", 64'(rd_ptr), 64'(exp_rd));
            if (dtack) ack_seen++;
            if (prev_stall) begin
                check("stall_valid", 64'(valid_out), 64'(1));
                check("stall_data", data_out, prev_data);
            end
            pend_ack = 1'b0;
            if (valid_out && ready_in) begin
                xfer_cyc_q.push_back(cyc);
                if (exp_q.size() == 0) begin
                    check("unexpected_word", 64'(valid_out), 64'(0));
                end else begin
                    w = exp_q.pop_front();
                    check("data", data_out, w.data);
                    check("last", 64'(last_out), 64'(w.last));
                    if (w.last) begin
                        pend_ack = 1'b1;
                        exp_rd   = exp_rd + 1'b1;
                    end
                end
            end
            prev_stall = valid_out && !ready_in;
            prev_data  = data_out;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_chunk(input logic [IW-1:0] c);
        for (int o = 0; o < WPC; o++) begin
            word_t      w;
            logic [3:0] a;
            a      = {c, 2'(o)};
            w.data = {16{a}};
            w.last = (o == WPC - 1);
            exp_q.push_back(w);
        end
    endtask

    task automatic drain(input bit rand_rdy, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            ready_in = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            step();
            n++;
        end
        check("drain_complete", 64'(exp_q.size()), 64'(0));
        ready_in = 1'b1;
        repeat (3) step();
    endtask

    // With ready held high the first word must appear two cycles after the
    // pointer change and the rest must follow on consecutive cycles.
    task automatic check_timing(input int c0, input int n);
        check("xfer_count", 64'(xfer_cyc_q.size()), 64'(n));
        if (xfer_cyc_q.size() > 0) begin
            check("first_word_cycle", 64'(xfer_cyc_q[0] - c0), 64'(2));
            check("last_word_cycle", 64'(xfer_cyc_q[xfer_cyc_q.size()-1] - c0), 64'(n + 1));
        end
    endtask

    initial begin
        int c0;
        int base;
        int chunks;
        logic [IW-1:0] diff;

        repeat (3) step();
        check("reset_valid", 64'(valid_out), 64'(0));
        check("reset_last", 64'(last_out), 64'(0));
        check("reset_dtack", 64'(dtack), 64'(0));
        check("reset_rd_ptr", 64'(rd_ptr), 64'(0));
        reset_in = 1'b0;

        // Empty ring held: nothing may come out.
        for (int i = 0; i < 20; i++) begin
            step();
            check("idle_valid", 64'(valid_out), 64'(0));
        end

        // Single chunk.
        xfer_cyc_q.delete();
        base = ack_seen;
        wr_ptr = 2'd1;
        c0 = cyc;
        push_chunk(2'd0);
        drain(1'b0, 100);
        check_timing(c0, 4);
        check("one_chunk_acks", 64'(ack_seen - base), 64'(1));
        check("one_chunk_rd_ptr", 64'(rd_ptr), 64'(1));

        // Clean restart, then three chunks back to back.
        reset_in = 1'b1;
        wr_ptr = 2'd0;
        step();
        step();
        reset_in = 1'b0;
        check("restart_rd_ptr", 64'(rd_ptr), 64'(0));
        xfer_cyc_q.delete();
        base = ack_seen;
        wr_ptr = 2'd3;
        c0 = cyc;
        push_chunk(2'd0);
        push_chunk(2'd1);
        push_chunk(2'd2);
        drain(1'b0, 100);
        check_timing(c0, 12);
        check("three_chunk_acks", 64'(ack_seen - base), 64'(3));
        check("three_chunk_rd_ptr", 64'(rd_ptr), 64'(3));

        // Pointer wrap: chunks 3 then 0.
        xfer_cyc_q.delete();
        base = ack_seen;
        wr_ptr = 2'd1;
        c0 = cyc;
        push_chunk(2'd3);
        push_chunk(2'd0);
        drain(1'b0, 100);
        check_timing(c0, 8);
        check("wrap_acks", 64'(ack_seen - base), 64'(2));
        check("wrap_rd_ptr", 64'(rd_ptr), 64'(1));

        // Random back-pressure over three chunks.
        base = ack_seen;
        wr_ptr = 2'd0;
        push_chunk(2'd1);
        push_chunk(2'd2);
        push_chunk(2'd3);
        drain(1'b1, 400);
        check("stall_acks", 64'(ack_seen - base), 64'(3));
        check("stall_rd_ptr", 64'(rd_ptr), 64'(0));

        // Reset after three words of chunk 0: partial chunk abandoned, re-read.
        xfer_cyc_q.delete();
        wr_ptr = 2'd1;
        push_chunk(2'd0);
        for (int n = 0; n < 100 && xfer_cyc_q.size() < 3; n++) step();
        check("pre_reset_words", 64'(xfer_cyc_q.size()), 64'(3));
        reset_in = 1'b1;
        ready_in = 1'b0;
        base = ack_seen;
        step();
        check("midreset_valid", 64'(valid_out), 64'(0));
        check("midreset_dtack", 64'(dtack), 64'(0));
        check("midreset_rd_ptr", 64'(rd_ptr), 64'(0));
        reset_in = 1'b0;
        ready_in = 1'b1;
        xfer_cyc_q.delete();
        c0 = cyc;
        push_chunk(2'd0);
        drain(1'b0, 100);
        check_timing(c0, 4);
        check("reread_acks", 64'(ack_seen - base), 64'(1));
        check("reread_rd_ptr", 64'(rd_ptr), 64'(1));

        // Random producer and consumer; wrPtr may move in the same cycle rdPtr does.
        base = ack_seen;
        chunks = 0;
        for (int i = 0; i < 300; i++) begin
            ready_in = 1'($urandom_range(0, 1));
            diff = wr_ptr - exp_rd;
            if ($urandom_range(0, 3) == 0 && diff < 2'd3) begin
                push_chunk(wr_ptr);
                wr_ptr = wr_ptr + 1'b1;
                chunks++;
            end
            step();
        end
        drain(1'b1, 1000);
        check("random_acks", 64'(ack_seen - base), 64'(chunks));
        check("random_rd_ptr", 64'(rd_ptr), 64'(wr_ptr));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
